// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - round-robin owner arbitration for a shared 4-digit hex display
// A granted source keeps the display for at least DWELL_CYCLES clocks to avoid flicker.
module seg_display_arbiter #(
   parameter int unsigned DWELL_CYCLES = 10000,
   parameter logic [15:0] IDLE_VALUE   = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req,
   input  logic [15:0] data0,
   input  logic [15:0] data1,
   input  logic [15:0] data2,
   output logic [2:0]  grant,
   output logic [15:0] disp_value,
   output logic        blank
);

   typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_LINGER} state_t;

   localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);

   state_t      state_q, state_d;
   logic [1:0]  last_q, last_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  grant_q, grant_d;
   logic [15:0] disp_q, disp_d;
   logic        blank_q, blank_d;

   logic [1:0]  cand1, cand2;
   logic [1:0]  rr_win, other_win;
   logic        other_req, own_req, dwell_done;
   logic [15:0] cnt_inc;

   function automatic logic [1:0] next3(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   function automatic logic [15:0] src_data(input logic [1:0] idx,
                                            input logic [15:0] d0,
                                            input logic [15:0] d1,
                                            input logic [15:0] d2);
      case (idx)
         2'd0:    return d0;
         2'd1:    return d1;
         default: return d2;
      endcase
   endfunction

   // last_q doubles as the current owner index while a grant is live
   always_comb begin
      cand1      = next3(last_q);
      cand2      = next3(cand1);
      other_req  = req[cand1] | req[cand2];
      other_win  = req[cand1] ? cand1 : cand2;
      rr_win     = other_req ? other_win : last_q;
      own_req    = req[last_q];
      dwell_done = (cnt_q == DWELL_LAST);
      cnt_inc    = dwell_done ? cnt_q : cnt_q + 16'd1;
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      disp_d  = disp_q;
      blank_d = blank_q;
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               state_d = ST_SHOW;
               last_d  = rr_win;
               cnt_d   = 16'd0;
               grant_d = 3'(3'b001 << rr_win);
               disp_d  = src_data(rr_win, data0, data1, data2);
               blank_d = 1'b0;
            end
         end
         ST_SHOW, ST_LINGER: begin
            if (dwell_done && other_req) begin
               state_d = ST_SHOW;
               last_d  = other_win;
               cnt_d   = 16'd0;
               grant_d = 3'(3'b001 << other_win);
               disp_d  = src_data(other_win, data0, data1, data2);
               blank_d = 1'b0;
            end else if (own_req) begin
               state_d = ST_SHOW;
               cnt_d   = cnt_inc;
               if (state_q == ST_SHOW) begin
                  disp_d = src_data(last_q, data0, data1, data2);
               end
            end else if (!dwell_done) begin
               state_d = ST_LINGER;
               cnt_d   = cnt_inc;
            end else begin
               state_d = ST_IDLE;
               cnt_d   = 16'd0;
               grant_d = 3'b000;
               disp_d  = IDLE_VALUE;
               blank_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
            grant_d = 3'b000;
            disp_d  = IDLE_VALUE;
            blank_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         last_q  <= 2'd2;
         cnt_q   <= 16'd0;
         grant_q <= 3'b000;
         disp_q  <= IDLE_VALUE;
         blank_q <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         disp_q  <= disp_d;
         blank_q <= blank_d;
      end
   end

   assign grant      = grant_q;
   assign disp_value = disp_q;
   assign blank      = blank_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - directed bench for seg_display_arbiter with DWELL_CYCLES=4
module tb_seg_display_arbiter;

   localparam int DW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [15:0] data0, data1, data2;
   logic [2:0]  grant;
   logic [15:0] disp_value;
   logic        blank;

   int n_checks = 0;
   int n_err    = 0;
   int since    = 0;
   logic [2:0] prev_grant = 3'b000;

   seg_display_arbiter #(.DWELL_CYCLES(DW), .IDLE_VALUE(16'h0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .data0      (data0),
      .data1      (data1),
      .data2      (data2),
      .grant      (grant),
      .disp_value (disp_value),
      .blank      (blank)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [2:0] g, input logic [15:0] d, input logic b);
      chk({tag, "_grant"}, {29'd0, grant}, {29'd0, g});
      chk({tag, "_disp"},  {16'd0, disp_value}, {16'd0, d});
      chk({tag, "_blank"}, {31'd0, blank}, {31'd0, b});
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (grant !== 3'b000 && n < 20) begin
         step();
         n++;
      end
      chk_out({tag, "_idle"}, 3'b000, 16'h0000, 1'b1);
   endtask

   // grant stays one-hot-or-zero and a live owner holds for the full dwell
   always @(negedge clk) begin
      chk("onehot", {31'd0, $onehot0(grant)}, 32'd1);
      if (rst) begin
         since      = 0;
         prev_grant = grant;
      end else begin
         if (grant !== prev_grant) begin
            if (prev_grant != 3'b000) chk("dwell_hold", {31'd0, since >= DW - 1}, 32'd1);
            since = 0;
         end else begin
            since++;
         end
         prev_grant = grant;
      end
   end

   initial begin
      rst = 1'b1; req = 3'b000;
      data0 = 16'h0000; data1 = 16'h0000; data2 = 16'h0000;
      step(); step();
      chk_out("reset", 3'b000, 16'h0000, 1'b1);
      rst = 1'b0;

      // all three request: rotate 0 -> 1 -> 2 -> 0 every DW cycles
      data0 = 16'h1111; data1 = 16'h2222; data2 = 16'h3333; req = 3'b111;
      step();
      chk_out("rr_first", 3'b001, 16'h1111, 1'b0);
      repeat (DW - 1) step();
      chk("rr_hold0", {29'd0, grant}, 32'd1);
      step();
      chk_out("rr_second", 3'b010, 16'h2222, 1'b0);
      repeat (DW) step();
      chk_out("rr_third", 3'b100, 16'h3333, 1'b0);
      repeat (DW) step();
      chk("rr_wrap", {29'd0, grant}, 32'd1);
      req = 3'b000;
      wait_idle("rr");

      // live data follows with one cycle of lag
      data0 = 16'h1234; req = 3'b001;
      step();
      chk_out("live_grant", 3'b001, 16'h1234, 1'b0);
      data0 = 16'hABCD;
      chk("live_lag", {16'd0, disp_value}, 32'h1234);
      step();
      chk_out("live_follow", 3'b001, 16'hABCD, 1'b0);
      req = 3'b000;
      wait_idle("live");

      // single-cycle pulse: frozen value for exactly DW cycles, then idle
      data0 = 16'h5A5A; req = 3'b001;
      step();
      chk_out("pulse_grant", 3'b001, 16'h5A5A, 1'b0);
      req = 3'b000; data0 = 16'hFFFF;
      for (int i = 1; i < DW; i++) begin
         step();
         chk_out("pulse_linger", 3'b001, 16'h5A5A, 1'b0);
      end
      step();
      chk_out("pulse_idle", 3'b000, 16'h0000, 1'b1);

      // owner keeps display past dwell until another source asks
      data0 = 16'h0F0F; data1 = 16'hBEEF; req = 3'b001;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("keep_owner", {29'd0, grant}, 32'd1);
      end
      req = 3'b011;
      step();
      chk_out("late_req", 3'b010, 16'hBEEF, 1'b0);

      // asynchronous reset mid-SHOW
      step();
      #1 rst = 1'b1;
      #1 chk_out("async_rst", 3'b000, 16'h0000, 1'b1);
      req = 3'b010;
      step();
      rst = 1'b0;
      step();
      chk_out("post_rst", 3'b010, 16'hBEEF, 1'b0);
      req = 3'b000;
      wait_idle("post_rst");

      // linger then owner returns: counter keeps running, so handoff at dwell end
      data2 = 16'hC0DE; req = 3'b100;
      step();
      chk_out("ret_grant", 3'b100, 16'hC0DE, 1'b0);
      req = 3'b000; data2 = 16'h1111;
      step();
      chk_out("ret_linger", 3'b100, 16'hC0DE, 1'b0);
      req = 3'b100;
      step();
      req = 3'b101;
      step();
      chk("ret_hold", {29'd0, grant}, 32'd4);
      step();
      chk_out("ret_handoff", 3'b001, 16'h0F0F, 1'b0);
      req = 3'b000;
      wait_idle("end");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
